// File: rtl/bus_write_fifo_if.sv
// Snooped CPU write-cycle signals plus the FIFO read-side valid/ready handshake.
// BUS_WRITE_FIFO_TSTAMP_EN adds the per-entry rd_tstamp output.
interface bus_write_fifo_if #(
  parameter int AW       = 14,
  parameter int WIN_BITS = 4
);
  logic                _ads;
  logic                m_io;
  logic                w_r;
  logic [AW-1:0]       addr;
  logic [3:0]          _be;
  logic [31:0]         din;
  logic                oe;
  logic                bce;
  logic                rd_valid;
  logic                rd_ready;
  logic [WIN_BITS-1:0] rd_addr;
  logic [3:0]          rd_be;
  logic [31:0]         rd_data;
`ifdef BUS_WRITE_FIFO_TSTAMP_EN
  logic [15:0]         rd_tstamp;

  modport slave (
    input  _ads, m_io, w_r, addr, _be, din, oe, bce, rd_ready,
    output rd_valid, rd_addr, rd_be, rd_data, rd_tstamp
  );
  modport master (
    output _ads, m_io, w_r, addr, _be, din, oe, bce, rd_ready,
    input  rd_valid, rd_addr, rd_be, rd_data, rd_tstamp
  );
`else
  modport slave (
    input  _ads, m_io, w_r, addr, _be, din, oe, bce, rd_ready,
    output rd_valid, rd_addr, rd_be, rd_data
  );
  modport master (
    output _ads, m_io, w_r, addr, _be, din, oe, bce, rd_ready,
    input  rd_valid, rd_addr, rd_be, rd_data
  );
`endif
endinterface

// File: rtl/bus_write_fifo.sv
// Snoops CPU I/O writes hitting a decoded window and queues {offset, be, data} for the MCU.
// Define BUS_WRITE_FIFO_TSTAMP_EN to store a 16-bit free-running cycle stamp per entry.
//
// state    | meaning
// ST_IDLE  | no qualifying write in flight
// ST_ARMED | hit decoded at _ads, waiting for T2 (oe & bce) to capture
module bus_write_fifo #(
  parameter int            AW        = 14,
  parameter int            WIN_BITS  = 4,
  parameter logic [AW-1:0] BASE_ADDR = 14'h0C0,
  parameter int            DEPTH_LG2 = 3
) (
  input  logic               clk,
  input  logic               _rst,
  bus_write_fifo_if.slave    bus,
  output logic [DEPTH_LG2:0] count,
  output logic               overflow,
  input  logic               ovf_clr
);

  localparam int DEPTH_N = 1 << DEPTH_LG2;
  localparam logic [DEPTH_LG2:0] DEPTH = {1'b1, {DEPTH_LG2{1'b0}}};
`ifdef BUS_WRITE_FIFO_TSTAMP_EN
  localparam int EW = WIN_BITS + 4 + 32 + 16;
`else
  localparam int EW = WIN_BITS + 4 + 32;
`endif

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0]          state;
  logic [WIN_BITS-1:0] offset_q;
  logic [3:0]          be_q;
  logic [DEPTH_LG2:0]  wr_cnt, rd_cnt, wr_cnt_next, rd_cnt_next;
  logic [DEPTH_LG2:0]  count_next, cnt_after_pop;
  logic [EW-1:0]       mem [DEPTH_N];
  logic [EW-1:0]       push_entry, head_next;
  logic                hit, capture, full, pop, push_ok, ovf_set, load_head;

  assign hit = !bus.m_io && bus.w_r &&
               (bus.addr[AW-1:WIN_BITS] == BASE_ADDR[AW-1:WIN_BITS]) &&
               (bus._be != 4'hF);
  assign capture = (state == ST_ARMED) && bus.oe && bus.bce;

  assign count         = wr_cnt - rd_cnt;
  assign full          = (count == DEPTH);
  assign pop           = bus.rd_valid && bus.rd_ready;
  assign push_ok       = capture && (!full || pop);
  assign ovf_set       = capture && full && !pop;
  assign wr_cnt_next   = wr_cnt + {{DEPTH_LG2{1'b0}}, push_ok};
  assign rd_cnt_next   = rd_cnt + {{DEPTH_LG2{1'b0}}, pop};
  assign count_next    = wr_cnt_next - rd_cnt_next;
  assign cnt_after_pop = count - {{DEPTH_LG2{1'b0}}, pop};

`ifdef BUS_WRITE_FIFO_TSTAMP_EN
  logic [15:0] tstamp;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) tstamp <= '0;
    else       tstamp <= tstamp + 16'd1;
  end

  assign push_entry = {offset_q, be_q, bus.din, tstamp};
`else
  assign push_entry = {offset_q, be_q, bus.din};
`endif

  // When nothing older survives the pop, the new head is the entry being pushed now.
  assign head_next = (cnt_after_pop == '0) ? push_entry : mem[rd_cnt_next[DEPTH_LG2-1:0]];
  assign load_head = (count_next != '0) && (pop || (count == '0));

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state    <= ST_IDLE;
      offset_q <= '0;
      be_q     <= '0;
    end else if (!bus._ads) begin
      state    <= hit ? ST_ARMED : ST_IDLE;
      offset_q <= bus.addr[WIN_BITS-1:0];
      be_q     <= ~bus._be;
    end else if ((state == ST_ARMED) && (capture || !bus.bce)) begin
      state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_cnt[DEPTH_LG2-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_next;
      rd_cnt <= rd_cnt_next;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_addr  <= '0;
      bus.rd_be    <= '0;
      bus.rd_data  <= '0;
`ifdef BUS_WRITE_FIFO_TSTAMP_EN
      bus.rd_tstamp <= '0;
`endif
    end else begin
      bus.rd_valid <= (count_next != '0);
      if (load_head) begin
`ifdef BUS_WRITE_FIFO_TSTAMP_EN
        {bus.rd_addr, bus.rd_be, bus.rd_data, bus.rd_tstamp} <= head_next;
`else
        {bus.rd_addr, bus.rd_be, bus.rd_data} <= head_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bus_write_fifo.sv
// Directed and randomized CPU write cycles checked against a queue model of the write FIFO.
`timescale 1ns/1ps
module tb_bus_write_fifo;
  localparam int AW        = 14;
  localparam int WIN_BITS  = 4;
  localparam int DEPTH_LG2 = 3;
  localparam int DEPTH     = 8;

  logic               clk = 1'b0;
  logic               _rst;
  logic               ovf_clr;
  logic [DEPTH_LG2:0] count;
  logic               overflow;

  bus_write_fifo_if #(.AW(AW), .WIN_BITS(WIN_BITS)) bus ();

  bus_write_fifo #(
    .AW(AW), .WIN_BITS(WIN_BITS), .BASE_ADDR(14'h0C0), .DEPTH_LG2(DEPTH_LG2)
  ) dut (
    .clk(clk), ._rst(_rst), .bus(bus), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  off;
    logic [3:0]  be;
    logic [31:0] data;
    logic [15:0] ts;
  } ent_t;

  ent_t        mq[$];
  ent_t        cap_ent;
  logic        cap_now;
  logic        m_ovf;
  logic [15:0] m_cyc;
  logic [13:0] base_v;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 64'(count), 64'(mq.size()));
    check("rd_valid", 64'(bus.rd_valid), 64'(mq.size() != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      check("rd_addr", 64'(bus.rd_addr), 64'(mq[0].off));
      check("rd_be", 64'(bus.rd_be), 64'(mq[0].be));
      check("rd_data", 64'(bus.rd_data), 64'(mq[0].data));
`ifdef BUS_WRITE_FIFO_TSTAMP_EN
      check("rd_tstamp", 64'(bus.rd_tstamp), 64'(mq[0].ts));
`endif
    end
  endtask

  // One clock: model reacts to the inputs present at the rising edge, then outputs are checked.
  task automatic tick();
    @(posedge clk);
    if (!_rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cyc = '0;
    end else begin
      if (bus.rd_ready && mq.size() != 0) void'(mq.pop_front());
      if (ovf_clr) m_ovf = 1'b0;
      if (cap_now) begin
        if (mq.size() < DEPTH) begin
          cap_ent.ts = m_cyc;
          mq.push_back(cap_ent);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_cyc = m_cyc + 16'd1;
    end
    @(negedge clk);
    check_state();
  endtask

  function automatic logic [13:0] waddr(input int off);
    return base_v + 14'(off);
  endfunction

  task automatic cpu_cycle(input logic io_n, input logic wr, input logic [13:0] a,
                           input logic [3:0] be_n, input logic [31:0] d, input int oe_n,
                           input logic rdy_cap, input logic clr_cap);
    logic hit;
    logic rdy_save;
    hit = !io_n && wr && ((a >> 4) == (base_v >> 4)) && (be_n != 4'hF);
    bus._ads = 1'b0; bus.m_io = io_n; bus.w_r = wr; bus.addr = a; bus._be = be_n;
    bus.bce = 1'b1; bus.oe = 1'b0;
    tick();
    bus._ads = 1'b1; bus.addr = 14'($urandom); bus._be = 4'($urandom);
    bus.oe = 1'b1; bus.din = d;
    cap_ent.off = a[3:0]; cap_ent.be = ~be_n; cap_ent.data = d; cap_ent.ts = '0;
    cap_now = hit;
    rdy_save = bus.rd_ready;
    if (rdy_cap) bus.rd_ready = 1'b1;
    ovf_clr = clr_cap;
    tick();
    cap_now = 1'b0; bus.rd_ready = rdy_save; ovf_clr = 1'b0;
    for (int i = 1; i < oe_n; i++) tick();
    bus.oe = 1'b0; bus.bce = 1'b0; bus.din = $urandom;
    tick();
  endtask

  task automatic abort_cycle(input logic [13:0] a);
    bus._ads = 1'b0; bus.m_io = 1'b0; bus.w_r = 1'b1; bus.addr = a; bus._be = 4'h0;
    bus.bce = 1'b1; bus.oe = 1'b0;
    tick();
    bus._ads = 1'b1; bus.bce = 1'b0;
    tick();
    bus.oe = 1'b1; bus.bce = 1'b1; bus.din = $urandom;
    tick();
    bus.oe = 1'b0; bus.bce = 1'b0;
    tick();
  endtask

  task automatic drain();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) tick();
    bus.rd_ready = 1'b0;
    tick();
    check("drain_empty", 64'(count), 64'd0);
  endtask

  initial begin
    logic        io, wr;
    logic [13:0] a;
    logic [3:0]  ben;
    int          kind;

    base_v = 14'h0C0;
    _rst = 1'b0; ovf_clr = 1'b0; cap_now = 1'b0; m_ovf = 1'b0; m_cyc = '0;
    bus._ads = 1'b1; bus.m_io = 1'b1; bus.w_r = 1'b0; bus.addr = '0; bus._be = 4'hF;
    bus.din = '0; bus.oe = 1'b0; bus.bce = 1'b0; bus.rd_ready = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rst_rd_be", 64'(bus.rd_be), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    tick(); tick();
    _rst = 1'b1;
    tick();

    // single window hit, visible one clock after the T2 edge
    cpu_cycle(1'b0, 1'b1, waddr(3), 4'b0000, 32'hDEADBEEF, 1, 1'b0, 1'b0);
    check("t1_rd_addr", 64'(bus.rd_addr), 64'd3);
    check("t1_rd_be", 64'(bus.rd_be), 64'hF);
    check("t1_rd_data", 64'(bus.rd_data), 64'hDEADBEEF);
    check("t1_count", 64'(count), 64'd1);
    drain();

    // non-qualifying cycles and an aborted one push nothing
    cpu_cycle(1'b0, 1'b0, waddr(5), 4'h0, $urandom, 1, 1'b0, 1'b0);
    cpu_cycle(1'b1, 1'b1, waddr(5), 4'h0, $urandom, 1, 1'b0, 1'b0);
    cpu_cycle(1'b0, 1'b1, waddr(16), 4'h0, $urandom, 1, 1'b0, 1'b0);
    cpu_cycle(1'b0, 1'b1, waddr(2), 4'hF, $urandom, 1, 1'b0, 1'b0);
    abort_cycle(waddr(7));
    check("t2_count", 64'(count), 64'd0);

    // oe held three clocks still yields exactly one entry
    cpu_cycle(1'b0, 1'b1, waddr(9), 4'b1010, 32'h1234_5678, 3, 1'b0, 1'b0);
    check("oe_hold_count", 64'(count), 64'd1);
    drain();

    // nine writes into a depth-8 FIFO
    for (int i = 0; i < 9; i++)
      cpu_cycle(1'b0, 1'b1, waddr(i), 4'($urandom_range(0, 14)), $urandom, 1, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd8);
    check("full_ovf", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // push and pop on the same edge while full
    cpu_cycle(1'b0, 1'b1, waddr(12), 4'b0011, 32'hA5A5_0001, 1, 1'b1, 1'b0);
    check("pp_count", 64'(count), 64'd8);
    check("pp_ovf", 64'(overflow), 64'd0);

    // clear and a new drop on the same edge: set wins
    cpu_cycle(1'b0, 1'b1, waddr(13), 4'b0000, 32'hA5A5_0002, 1, 1'b0, 1'b1);
    check("set_wins", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    drain();

    // async reset in T2 of a hit write with two entries queued
    cpu_cycle(1'b0, 1'b1, waddr(1), 4'h0, $urandom, 1, 1'b0, 1'b0);
    cpu_cycle(1'b0, 1'b1, waddr(2), 4'h0, $urandom, 1, 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd2);
    bus._ads = 1'b0; bus.m_io = 1'b0; bus.w_r = 1'b1; bus.addr = waddr(4); bus._be = 4'h0;
    bus.bce = 1'b1; bus.oe = 1'b0;
    tick();
    bus._ads = 1'b1; bus.oe = 1'b1; bus.din = 32'hBAD0_BAD0;
    _rst = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_cyc = '0;
    check("rst_mid_count", 64'(count), 64'd0);
    check("rst_mid_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    _rst = 1'b1;
    tick();
    bus.oe = 1'b0; bus.bce = 1'b0;
    tick();
    check("post_rst_count", 64'(count), 64'd0);
    cpu_cycle(1'b0, 1'b1, waddr(6), 4'b0110, 32'hC0DE_0006, 1, 1'b0, 1'b0);
    check("post_rst_data", 64'(bus.rd_data), 64'hC0DE_0006);
    drain();

    // write/drain pairs with random gaps: pointer wrap and stamp spacing
    for (int i = 0; i < 20; i++) begin
      cpu_cycle(1'b0, 1'b1, waddr($urandom_range(0, 15)), 4'($urandom_range(0, 14)),
                $urandom, $urandom_range(1, 2), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
    end

    // random mix of cycle kinds with random consumer back-pressure
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 8);
      io = 1'b0; wr = 1'b1;
      a = waddr($urandom_range(0, 15));
      ben = 4'($urandom_range(0, 14));
      case (kind)
        5: io = 1'b1;
        6: wr = 1'b0;
        7: if ($urandom_range(0, 1) == 1) a = a + 14'd16; else ben = 4'hF;
        default: ;
      endcase
      bus.rd_ready = 1'($urandom);
      if (kind == 8) abort_cycle(a);
      else cpu_cycle(io, wr, a, ben, $urandom, $urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
